// File: rtl/ula_pkg.sv
// Shared definitions for the bit-serial ALU controller and its bench.
package ula_pkg;

   // Slice function codes, ordered {F0,F1}
   localparam logic [1:0] FN_AND  = 2'b00;
   localparam logic [1:0] FN_OR   = 2'b01;
   localparam logic [1:0] FN_NOTB = 2'b10;
   localparam logic [1:0] FN_SUM  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/ula_bit_counter.sv
// Bit-index counter: counts 0..WIDTH-1 and holds at the last index.
module ula_bit_counter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] idx,
   output logic             last
);

   logic [CNT_W-1:0] idx_q;

   assign idx  = idx_q;
   assign last = (idx_q == CNT_W'(WIDTH - 1));

   // Advance on enable; saturate at WIDTH-1 so the index never wraps
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         idx_q <= '0;
      end else if (en && !last) begin
         idx_q <= idx_q + 1'b1;
      end
   end

endmodule

// File: rtl/ula_serial_ctrl.sv
// Bit-serial driver for an external 1-bit ALU slice: feeds operand bits
// LSB-first, chains the carry through a register, assembles the result
// and produces N/Z/C flags.
module ula_serial_ctrl
   import ula_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             f0,
   input  logic             f1,
   input  logic             ena,
   input  logic             enb,
   input  logic             inva,
   input  logic             inc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             n_flag,
   output logic             z_flag,
   output logic             c_flag,
   output logic             s_f0,
   output logic             s_f1,
   output logic             s_ena,
   output logic             s_enb,
   output logic             s_inva,
   output logic             s_inc,
   output logic             s_a,
   output logic             s_b,
   input  logic             s_out,
   input  logic             s_cout
);

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
   logic             f0_q, f1_q, ena_q, enb_q, inva_q;
   logic             carry_q;
   logic             busy_q, done_q, n_q, z_q, c_q;
   logic [CNT_W-1:0] idx;
   logic             last;
   logic             accept;

   assign accept = (state_q == ST_IDLE) && start;

   ula_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (state_q == ST_RUN),
      .idx  (idx),
      .last (last)
   );

   // Result with the current slice bit merged in at the active index
   always_comb begin
      res_d      = res_q;
      res_d[idx] = s_out;
   end

   // Control FSM; all status outputs are registered here
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         f0_q    <= 1'b0;
         f1_q    <= 1'b0;
         ena_q   <= 1'b0;
         enb_q   <= 1'b0;
         inva_q  <= 1'b0;
         carry_q <= 1'b0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q     <= op_a;
                  b_q     <= op_b;
                  f0_q    <= f0;
                  f1_q    <= f1;
                  ena_q   <= ena;
                  enb_q   <= enb;
                  inva_q  <= inva;
                  carry_q <= inc;
                  res_q   <= '0;
                  n_q     <= 1'b0;
                  z_q     <= 1'b0;
                  c_q     <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               res_q   <= res_d;
               carry_q <= s_cout;
               if (last) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  n_q     <= res_d[WIDTH-1];
                  z_q     <= (res_d == '0);
                  c_q     <= s_cout;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = res_q;
   assign n_flag = n_q;
   assign z_flag = z_q;
   assign c_flag = c_q;

   // Slice controls are live only while running; zero otherwise
   assign s_f0   = busy_q & f0_q;
   assign s_f1   = busy_q & f1_q;
   assign s_ena  = busy_q & ena_q;
   assign s_enb  = busy_q & enb_q;
   assign s_inva = busy_q & inva_q;
   assign s_inc  = busy_q & carry_q;
   assign s_a    = busy_q & a_q[idx];
   assign s_b    = busy_q & b_q[idx];

endmodule
